// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg / mem_port_arbiter_if
//
// Bus types shared by the core, the arbiter and the memory system, plus the
// interface bundling every handshake bus the arbiter touches.
//
//   ireq   fetch request        (core    -> arbiter)
//   iresp  fetch response       (arbiter -> core)
//   dreq   data request         (core    -> arbiter)
//   dresp  data response        (arbiter -> core)
//   mreq   memory request       (arbiter -> memory)
//   mresp  memory response      (memory  -> arbiter)
//
// Modports:
//   slave  : the arbiter's view (consumes requests, produces responses).
//   master : the environment's view (core + memory side together).
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Transfer size encoding on the data bus; fetches are always 4 bytes.
  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  // strobe != 0 marks a write.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;

  modport slave (
    input  ireq, dreq, mresp,
    output iresp, dresp, mreq
  );

  modport master (
    output ireq, dreq, mresp,
    input  iresp, dresp, mreq
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the core's single memory port between the fetch bus (ireq/iresp)
// and the data bus (dreq/dresp). Exactly one transaction is in flight at a
// time. Data wins contention by default; a saturating starvation counter
// forces a fetch grant after STARVE_LIMIT data grants issued while fetch was
// waiting.
//
// Ports:
//   clk    core clock
//   reset  synchronous, active-high
//   bus    mem_port_arbiter_if.slave: ireq/dreq/mresp in, iresp/dresp/mreq out
//
// Parameters:
//   STARVE_LIMIT  data grants tolerated with fetch pending (1..15)
//
// Transaction flow:
//   IDLE : pick a winner from the live requests, capture it into `held`
//   ADDR : present `held` on mreq until the memory takes the address
//   DATA : wait for the data phase to finish
// mreq is driven purely from registers, so there is no combinational path
// from ireq/dreq to the memory side. Responses back to the core are routed
// combinationally from mresp to the current owner only.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic        owner;       // 0 = fetch, 1 = data
  logic [3:0]  starve_cnt;
  dbus_req_t   held;        // captured request of the current owner
  logic        mreq_vld;

  // -------------------------------------------------------------------------
  // Grant decision (only meaningful in IDLE)
  // Fetch wins when it is alone, or when data has been favoured LIMIT times
  // while fetch was waiting.
  // -------------------------------------------------------------------------
  logic      fetch_win;
  logic      data_win;
  dbus_req_t fetch_req;

  assign fetch_win = bus.ireq.valid &&
                     (!bus.dreq.valid || (starve_cnt == LIMIT));
  assign data_win  = bus.dreq.valid && !fetch_win;

  // A fetch travels on the data-width memory bus as a 4-byte read.
  always_comb begin
    fetch_req        = '0;
    fetch_req.valid  = 1'b1;
    fetch_req.addr   = bus.ireq.addr;
    fetch_req.size   = MSIZE4;
    fetch_req.strobe = '0;
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered mreq valid
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      held       <= '0;
      mreq_vld   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_win) begin
            held       <= fetch_req;
            owner      <= 1'b0;
            starve_cnt <= '0;
            mreq_vld   <= 1'b1;
            state      <= ADDR;
          end else if (data_win) begin
            held     <= bus.dreq;
            owner    <= 1'b1;
            mreq_vld <= 1'b1;
            state    <= ADDR;
            // Only data grants that actually bypass a waiting fetch count.
            if (bus.ireq.valid && (starve_cnt != LIMIT))
              starve_cnt <= starve_cnt + 4'd1;
          end
        end

        ADDR: begin
          if (bus.mresp.addr_ok) begin
            mreq_vld <= 1'b0;
            // Address and data can complete in the same cycle.
            state    <= bus.mresp.data_ok ? IDLE : DATA;
          end
        end

        DATA: begin
          if (bus.mresp.data_ok)
            state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          mreq_vld <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Memory request: the captured request with the registered valid.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mreq       = held;
    bus.mreq.valid = mreq_vld;
  end

  // -------------------------------------------------------------------------
  // Response routing. Handshake strobes go to the owner only and only while
  // a transaction is open, so stray responses in IDLE never leak out.
  // -------------------------------------------------------------------------
  logic in_addr;
  logic in_busy;

  assign in_addr = (state == ADDR);
  assign in_busy = (state == ADDR) || (state == DATA);

  always_comb begin
    bus.iresp         = '0;
    bus.dresp         = '0;

    bus.iresp.addr_ok = !owner && in_addr && bus.mresp.addr_ok;
    bus.iresp.data_ok = !owner && in_busy && bus.mresp.data_ok;
    bus.dresp.addr_ok =  owner && in_addr && bus.mresp.addr_ok;
    bus.dresp.data_ok =  owner && in_busy && bus.mresp.data_ok;

    bus.dresp.data    = bus.mresp.data;
    // Fetch words come from the half of the doubleword selected by addr[2].
    bus.iresp.data    = held.addr[2] ? bus.mresp.data[63:32]
                                     : bus.mresp.data[31:0];
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  // Reference model state: data grants issued while fetch was waiting,
  // counted since the last fetch grant.
  int   bypassed = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic iv, input logic [63:0] ia, input logic dv,
                         input logic [63:0] da, input logic [7:0] ds, input logic [63:0] dd);
    bus.ireq.valid  = iv;
    bus.ireq.addr   = ia;
    bus.dreq.valid  = dv;
    bus.dreq.addr   = da;
    bus.dreq.size   = MSIZE8;
    bus.dreq.strobe = ds;
    bus.dreq.data   = dd;
  endtask

  // Winner from the arbitration rules: a lone requester wins; with both
  // present data wins until it has bypassed fetch LIMIT times.
  task automatic predict(input logic iv, input logic dv, output logic own);
    own = 1'b0;
    if (dv && (!iv || bypassed < LIMIT)) begin
      own = 1'b1;
      if (iv && bypassed < LIMIT) bypassed = bypassed + 1;
    end else if (iv) begin
      bypassed = 0;
    end
  endtask

  task automatic resp(input string tag, input logic own, input logic aok, input logic dok,
                      input logic [63:0] rdata, input logic [63:0] addr);
    chk({tag, ".i_aok"}, bus.iresp.addr_ok, aok & ~own);
    chk({tag, ".d_aok"}, bus.dresp.addr_ok, aok & own);
    chk({tag, ".i_dok"}, bus.iresp.data_ok, dok & ~own);
    chk({tag, ".d_dok"}, bus.dresp.data_ok, dok & own);
    if (dok) begin
      if (own) chk({tag, ".d_data"}, bus.dresp.data, rdata);
      else     chk({tag, ".i_data"}, bus.iresp.data, addr[2] ? rdata[63:32] : rdata[31:0]);
    end
  endtask

  // Called at +1 after the grant edge; returns at +2 after the completion edge.
  task automatic serve(input logic own, input logic [63:0] addr, input logic [7:0] strb,
                       input logic [2:0] size, input int alat, input int dlat,
                       input logic [63:0] rdata, input string tag);
    bus.mresp = '0;
    #1;
    chk({tag, ".mvalid"}, bus.mreq.valid, 1);
    chk({tag, ".maddr"},  bus.mreq.addr, addr);
    chk({tag, ".mstrb"},  bus.mreq.strobe, strb);
    chk({tag, ".msize"},  bus.mreq.size, size);
    for (int k = 0; k < alat; k++) begin
      resp({tag, ".await"}, own, 1'b0, 1'b0, rdata, addr);
      tick;
      #1;
      chk({tag, ".mvalid_hold"}, bus.mreq.valid, 1);
    end
    bus.mresp.addr_ok = 1'b1;
    bus.mresp.data_ok = (dlat == 0);
    bus.mresp.data    = rdata;
    #1;
    resp({tag, ".aok"}, own, 1'b1, dlat == 0, rdata, addr);
    tick;
    bus.mresp = '0;
    if (dlat > 0) begin
      #1;
      chk({tag, ".mvalid_drop"}, bus.mreq.valid, 0);
      for (int k = 0; k < dlat - 1; k++) begin
        resp({tag, ".dwait"}, own, 1'b0, 1'b0, rdata, addr);
        tick;
        #1;
      end
      bus.mresp.data_ok = 1'b1;
      bus.mresp.data    = rdata;
      #1;
      resp({tag, ".dok"}, own, 1'b0, 1'b1, rdata, addr);
      tick;
      bus.mresp = '0;
    end
    #1;
    chk({tag, ".end_mvalid"}, bus.mreq.valid, 0);
    chk({tag, ".end_idle"}, dut.state, 0);
  endtask

  // Drive requests in an IDLE cycle, let the arbiter sample them, serve the
  // predicted winner. A random stray data_ok in IDLE must not leak.
  task automatic grant(input logic iv, input logic [63:0] ia, input logic dv,
                       input logic [63:0] da, input logic [7:0] ds, input logic [63:0] dd,
                       input int alat, input int dlat, input logic [63:0] rdata,
                       input logic stray, input string tag);
    logic own;
    set_req(iv, ia, dv, da, ds, dd);
    bus.mresp.data_ok = stray;
    #1;
    if (stray) begin
      chk({tag, ".stray_i"}, bus.iresp.data_ok, 0);
      chk({tag, ".stray_d"}, bus.dresp.data_ok, 0);
    end
    predict(iv, dv, own);
    tick;
    if (!iv && !dv) begin
      bus.mresp = '0;
      #1;
      chk({tag, ".no_grant"}, bus.mreq.valid, 0);
    end else if (own) begin
      serve(1'b1, da, ds, MSIZE8, alat, dlat, rdata, tag);
    end else begin
      serve(1'b0, ia, 8'h00, MSIZE4, alat, dlat, rdata, tag);
    end
  endtask

  initial begin
    logic own;
    reset = 1'b1;
    set_req(1'b0, '0, 1'b0, '0, '0, '0);
    bus.mresp = '0;
    repeat (2) tick;
    #1;
    chk("rst.mvalid", bus.mreq.valid, 0);
    chk("rst.state", dut.state, 0);
    chk("rst.owner", dut.owner, 0);
    chk("rst.starve", dut.starve_cnt, 0);
    resp("rst", 1'b0, 1'b0, 1'b0, '0, '0);
    chk("rst.i_data", bus.iresp.data, 0);
    chk("rst.d_data", bus.dresp.data, 0);
    reset = 1'b0;
    tick;

    // Fetch only, address in the upper word.
    grant(1'b1, 64'h8000_0004, 1'b0, '0, '0, '0, 0, 0, 64'h1111_2222_3333_4444, 1'b0, "fetch");
    chk("fetch.word", bus.iresp.data, 0); // mresp cleared: routing follows mresp

    // Simultaneous: store first, then fetch in the following IDLE cycle.
    grant(1'b1, 64'h8000_0010, 1'b1, 64'h8000_1000, 8'hFF, 64'hDEAD_BEEF_0000_0001,
          1, 0, 64'h0, 1'b0, "simul.d");
    grant(1'b1, 64'h8000_0010, 1'b0, '0, '0, '0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, "simul.i");

    // Starvation: both held; grant order must be D D D D I D D D D I.
    for (int i = 0; i < 10; i++) begin
      logic exp_own;
      exp_own = (i % 5 == 4) ? 1'b0 : 1'b1;
      set_req(1'b1, 64'h8000_0100, 1'b1, 64'h8000_2000, 8'h00, '0);
      predict(1'b1, 1'b1, own);
      tick;
      if (exp_own)
        serve(1'b1, 64'h8000_2000, 8'h00, MSIZE8, i % 2, i % 3, 64'h0123_4567_89AB_CDEF, "starve.d");
      else
        serve(1'b0, 64'h8000_0100, 8'h00, MSIZE4, 0, 0, 64'h0123_4567_89AB_CDEF, "starve.i");
    end

    // Split handshake: addr_ok in cycle 1, data_ok in cycle 4.
    grant(1'b0, '0, 1'b1, 64'h8000_3008, 8'h0F, 64'h5, 0, 3, 64'h7777_8888_9999_0000, 1'b0, "split");

    // Spurious response in IDLE with no requester.
    set_req(1'b0, '0, 1'b0, '0, '0, '0);
    bus.mresp.addr_ok = 1'b1;
    bus.mresp.data_ok = 1'b1;
    bus.mresp.data    = 64'hFFFF_0000_FFFF_0000;
    #1;
    resp("spur", 1'b0, 1'b0, 1'b0, '0, '0);
    tick;
    bus.mresp = '0;
    #1;
    chk("spur.mvalid", bus.mreq.valid, 0);
    chk("spur.idle", dut.state, 0);

    // Reset while in DATA.
    set_req(1'b1, 64'h8000_0200, 1'b1, 64'h8000_4000, 8'h00, '0);
    predict(1'b1, 1'b1, own);
    tick;
    bus.mresp.addr_ok = 1'b1;
    tick;
    bus.mresp = '0;
    #1;
    chk("rstmid.in_data", dut.state, 2);
    reset = 1'b1;
    set_req(1'b0, '0, 1'b0, '0, '0, '0);
    tick;
    #1;
    chk("rstmid.idle", dut.state, 0);
    chk("rstmid.mvalid", bus.mreq.valid, 0);
    chk("rstmid.starve", dut.starve_cnt, 0);
    reset = 1'b0;
    bypassed = 0;
    grant(1'b1, 64'h8000_0300, 1'b0, '0, '0, '0, 1, 1, 64'h4242_4242_1313_1313, 1'b0, "rstmid.fetch");

    // Randomized traffic checked against the grant model.
    for (int i = 0; i < 40; i++) begin
      logic iv, dv, stray;
      logic [63:0] ia, da, dd, rd;
      logic [7:0] ds;
      iv    = 1'($urandom_range(0, 3) != 0);
      dv    = 1'($urandom_range(0, 3) != 0);
      stray = 1'($urandom_range(0, 1));
      ia    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
      da    = {32'h0, 32'h9000_0000 | ($urandom & 32'h0000_FFF8)};
      ds    = 8'($urandom_range(0, 1) ? $urandom : 0);
      dd    = {$urandom, $urandom};
      rd    = {$urandom, $urandom};
      grant(iv, ia, dv, da, ds, dd, $urandom_range(0, 2), $urandom_range(0, 2), rd, stray, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
